bufid_alloc_arbiter: RTL and testbench
======================================

// Module: bufid_alloc_arbiter
// PURPOSE
//  Shares the free-buffer-ID FIFO between PORT_NUM network-input ports.
//  Each port's frame parser requests one bufid per accepted frame; this block round-robins those requests,
//  pops the FIFO and returns the bufid to the winner. It also writes recycled bufids back into the FIFO.
//  Sits between the per-port descriptor extraction path and the shared free-bufid FIFO.
// PARAMETERS
//  PORT_NUM  8   number of requesting input ports
//  BUFID_W   9   buffer-ID width, equal to the FIFO data width
// PORTS
//  clk_sys            in   1         system clock
//  reset              in   1         reset; synchronous, active-high
//  iv_bufid_req       in   PORT_NUM  per-port request level; held until that port's ack
//  ov_bufid_ack       out  PORT_NUM  one-hot, 1-cycle grant pulse
//  ov_bufid           out  BUFID_W   allocated bufid; valid only while ov_bufid_ack != 0
//  iv_fifo_rdata      in   BUFID_W   free FIFO head (show-ahead)
//  i_fifo_empty       in   1         free FIFO empty
//  o_fifo_rd          out  1         pop pulse to the free FIFO
//  iv_release_bufid   in   BUFID_W   bufid being recycled by the output side
//  i_release_wr       in   1         release strobe
//  ov_fifo_wdata      out  BUFID_W   write data to the free FIFO
//  o_fifo_wr          out  1         write strobe to the free FIFO
//  ov_alloc_cnt       out  16        allocations since reset; wraps
//  ov_release_cnt     out  16        releases since reset; wraps
//  ov_alloc_state     out  2         FSM state, debug
// BEHAVIOUR
//  Reset values:
//   - all outputs are 0 and the FSM is in IDLE_S.
//   - Last-grant pointer is PORT_NUM-1, so port 0 has first priority.
//   - Reset dominates in any state; an in-flight grant is dropped.
//  FSM, encodings IDLE_S=0, WAIT_S=1:
//   - IDLE_S: if (|iv_bufid_req) && !i_fifo_empty, select winner w (round-robin, see below).
//     Registered results: ov_bufid_ack = 1<<w, ov_bufid = iv_fifo_rdata, o_fifo_rd = 1, pointer <= w;
//     then go to WAIT_S. Otherwise stay in IDLE_S with ack, rd and ov_bufid at 0.
//   - WAIT_S: ack and rd return to 0 and ov_bufid returns to 0. Go to IDLE_S unconditionally.
//     This cycle lets the winner drop its req, so it is never granted twice.
//  Arbitration: round-robin starting at pointer+1 modulo PORT_NUM; the first asserted req wins.
//  Latency and throughput:
//   - ack appears 1 clk after req is sampled in IDLE_S.
//   - Sustained rate is 1 grant per 2 clks.
//  Requester rule: deassert req in the cycle after ack. A req still high in IDLE_S is a new request.
//  Empty FIFO: no pop and no ack; requests wait with no timeout. i_fifo_empty is checked in the same cycle as the pop.
//  Release path:
//   - independent of the FSM; o_fifo_wr <= i_release_wr and ov_fifo_wdata <= iv_release_bufid (1 clk latency).
//   - No bypass to the allocator: a bufid released while the FIFO is empty is granted only after the FIFO deasserts empty.
//   - Simultaneous release and pop in one cycle are both issued; the FIFO handles concurrent rd/wr.
//  Counters:
//   - ov_alloc_cnt increments on every o_fifo_rd; ov_release_cnt increments on every o_fifo_wr.
//   - Both are 16-bit and wrap FFFF->0000.
// STRUCTURE
//  Package tsn_bufid_pkg: BUFID_W, IDLE_S/WAIT_S encodings, alloc/release counter width.
//  Sub-module rr_arbiter: combinational; inputs req vector and pointer, outputs one-hot grant, index and any-req.
//  FSM, counters and release path stay in this top.
// TESTING
//  1. Reset -> all outputs 0. Then single req on port 2, FIFO head 9'h005 -> next clk ack=8'b0000_0100,
//     ov_bufid=9'h005, o_fifo_rd=1 for exactly 1 clk.
//  2. All 8 reqs held high, each dropped after its ack -> grants on ports 0,1,...,7 in order, one every 2 clks;
//     ov_alloc_cnt=8.
//  3. Port 5 req with i_fifo_empty=1 for 10 clks -> no ack and no rd. Empty drops -> ack[5] one clk later.
//  4. i_release_wr with 9'h01A while a pop is in progress -> o_fifo_wr=1 with wdata 9'h01A next clk, rd also issued;
//     both counters advance.
//  5. reset asserted in WAIT_S -> next clk all outputs 0, pointer restored; a req on port 7 and port 0 together -> port 0 wins.
//  6. Counter wrap: preload or run 65536 allocs -> ov_alloc_cnt returns to 0 with no side effects.

Source files
------------

// File: rtl/tsn_bufid_pkg.sv
// Shared constants for the free-bufid allocation path.
//   BUFID_W  : buffer-ID width, equal to the free-bufid FIFO data width
//   CNT_W    : width of the allocation / release statistics counters
//   IDLE_S / WAIT_S : allocator FSM encodings, also exported on the debug port
package tsn_bufid_pkg;

    localparam int BUFID_W = 9;
    localparam int CNT_W   = 16;

    localparam logic [1:0] IDLE_S = 2'd0;
    localparam logic [1:0] WAIT_S = 2'd1;

endpackage

// File: rtl/bufid_alloc_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
// The search starts one position after the last winner and wraps modulo
// PORT_NUM; the first asserted request found wins.
// Ports:
//   req      in   PORT_NUM  request vector
//   ptr      in   PTR_W     index of the previous winner
//   grant    out  PORT_NUM  one-hot grant (all zero when no request)
//   index    out  PTR_W     binary index of the granted port
//   any_req  out  1         at least one request is asserted
module rr_arbiter #(
    parameter int PORT_NUM = 8,
    parameter int PTR_W    = 3
) (
    input  logic [PORT_NUM-1:0] req,
    input  logic [PTR_W-1:0]    ptr,
    output logic [PORT_NUM-1:0] grant,
    output logic [PTR_W-1:0]    index,
    output logic                any_req
);

    int   cand;
    logic found;

    // Walk the ring starting at ptr+1. Offset PORT_NUM lands back on the
    // previous winner, so it is only picked when it is the sole requester.
    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 1; i <= PORT_NUM; i++) begin
            cand = (int'(ptr) + i) % PORT_NUM;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                index       = PTR_W'(cand);
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/bufid_alloc_arbiter.sv
// Free-bufid allocator shared by PORT_NUM input ports.
// Requests are round-robin arbitrated; the winner receives the head of the
// show-ahead free FIFO together with a one-cycle ack while the FIFO is
// popped. Recycled bufids are written back to the FIFO independently of
// the allocator FSM.
// Ports:
//   clk_sys           in   1         system clock
//   reset             in   1         synchronous, active-high reset
//   iv_bufid_req      in   PORT_NUM  per-port request level, held until ack
//   ov_bufid_ack      out  PORT_NUM  one-hot one-cycle grant pulse
//   ov_bufid          out  BUFID_W   allocated bufid, valid with the ack
//   iv_fifo_rdata     in   BUFID_W   free FIFO head (show-ahead)
//   i_fifo_empty      in   1         free FIFO empty
//   o_fifo_rd         out  1         pop pulse to the free FIFO
//   iv_release_bufid  in   BUFID_W   bufid being recycled
//   i_release_wr      in   1         release strobe
//   ov_fifo_wdata     out  BUFID_W   write data to the free FIFO
//   o_fifo_wr         out  1         write strobe to the free FIFO
//   ov_alloc_cnt      out  CNT_W     pops since reset, wrapping
//   ov_release_cnt    out  CNT_W     writes since reset, wrapping
//   ov_alloc_state    out  2         FSM state for debug
module bufid_alloc_arbiter
    import tsn_bufid_pkg::*;
#(
    parameter int PORT_NUM = 8
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic [PORT_NUM-1:0] iv_bufid_req,
    output logic [PORT_NUM-1:0] ov_bufid_ack,
    output logic [BUFID_W-1:0]  ov_bufid,
    input  logic [BUFID_W-1:0]  iv_fifo_rdata,
    input  logic                i_fifo_empty,
    output logic                o_fifo_rd,
    input  logic [BUFID_W-1:0]  iv_release_bufid,
    input  logic                i_release_wr,
    output logic [BUFID_W-1:0]  ov_fifo_wdata,
    output logic                o_fifo_wr,
    output logic [CNT_W-1:0]    ov_alloc_cnt,
    output logic [CNT_W-1:0]    ov_release_cnt,
    output logic [1:0]          ov_alloc_state
);

    localparam int PTR_W = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

    logic [1:0]          state;
    logic [PTR_W-1:0]    last_ptr;
    logic [PORT_NUM-1:0] grant;
    logic [PTR_W-1:0]    grant_index;
    logic                any_req;

    rr_arbiter #(
        .PORT_NUM (PORT_NUM),
        .PTR_W    (PTR_W)
    ) u_rr_arbiter (
        .req     (iv_bufid_req),
        .ptr     (last_ptr),
        .grant   (grant),
        .index   (grant_index),
        .any_req (any_req)
    );

    // Allocator FSM. The WAIT_S cycle after each grant gives the winner
    // time to drop its request so one request never collects two bufids.
    // The pointer resets to the last port so port 0 has first priority.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state        <= IDLE_S;
            last_ptr     <= PTR_W'(PORT_NUM - 1);
            ov_bufid_ack <= '0;
            ov_bufid     <= '0;
            o_fifo_rd    <= 1'b0;
        end else begin
            case (state)
                IDLE_S: begin
                    if (any_req && !i_fifo_empty) begin
                        ov_bufid_ack <= grant;
                        ov_bufid     <= iv_fifo_rdata;
                        o_fifo_rd    <= 1'b1;
                        last_ptr     <= grant_index;
                        state        <= WAIT_S;
                    end else begin
                        ov_bufid_ack <= '0;
                        ov_bufid     <= '0;
                        o_fifo_rd    <= 1'b0;
                    end
                end
                WAIT_S: begin
                    ov_bufid_ack <= '0;
                    ov_bufid     <= '0;
                    o_fifo_rd    <= 1'b0;
                    state        <= IDLE_S;
                end
                default: begin
                    ov_bufid_ack <= '0;
                    ov_bufid     <= '0;
                    o_fifo_rd    <= 1'b0;
                    state        <= IDLE_S;
                end
            endcase
        end
    end

    // Release path: a plain one-cycle register stage into the FIFO write
    // port. There is deliberately no bypass to the allocator; a recycled
    // bufid becomes grantable only once the FIFO reports it as non-empty.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            o_fifo_wr     <= 1'b0;
            ov_fifo_wdata <= '0;
        end else begin
            o_fifo_wr     <= i_release_wr;
            ov_fifo_wdata <= iv_release_bufid;
        end
    end

    // Statistics counters follow the registered strobes, so they lag the
    // rd/wr pulses by one cycle and wrap naturally at full scale.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            ov_alloc_cnt   <= '0;
            ov_release_cnt <= '0;
        end else begin
            if (o_fifo_rd) begin
                ov_alloc_cnt <= ov_alloc_cnt + CNT_W'(1);
            end
            if (o_fifo_wr) begin
                ov_release_cnt <= ov_release_cnt + CNT_W'(1);
            end
        end
    end

    assign ov_alloc_state = state;

endmodule

// File: tb/tb_bufid_alloc_arbiter.sv
// Self-checking bench for bufid_alloc_arbiter. Expected grants are pushed
// to a scoreboard queue when requests are driven; the monitor pops and
// compares whenever the DUT raises an ack.
module tb_bufid_alloc_arbiter;
    import tsn_bufid_pkg::*;

    localparam int PORT_NUM = 8;

    logic                clk_sys = 1'b0;
    logic                reset;
    logic [PORT_NUM-1:0] iv_bufid_req;
    logic [PORT_NUM-1:0] ov_bufid_ack;
    logic [BUFID_W-1:0]  ov_bufid;
    logic [BUFID_W-1:0]  iv_fifo_rdata;
    logic                i_fifo_empty;
    logic                o_fifo_rd;
    logic [BUFID_W-1:0]  iv_release_bufid;
    logic                i_release_wr;
    logic [BUFID_W-1:0]  ov_fifo_wdata;
    logic                o_fifo_wr;
    logic [CNT_W-1:0]    ov_alloc_cnt;
    logic [CNT_W-1:0]    ov_release_cnt;
    logic [1:0]          ov_alloc_state;

    typedef struct packed {
        logic [PORT_NUM-1:0] ack;
        logic [BUFID_W-1:0]  bufid;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk_sys = ~clk_sys;

    bufid_alloc_arbiter #(.PORT_NUM(PORT_NUM)) dut (
        .clk_sys          (clk_sys),
        .reset            (reset),
        .iv_bufid_req     (iv_bufid_req),
        .ov_bufid_ack     (ov_bufid_ack),
        .ov_bufid         (ov_bufid),
        .iv_fifo_rdata    (iv_fifo_rdata),
        .i_fifo_empty     (i_fifo_empty),
        .o_fifo_rd        (o_fifo_rd),
        .iv_release_bufid (iv_release_bufid),
        .i_release_wr     (i_release_wr),
        .ov_fifo_wdata    (ov_fifo_wdata),
        .o_fifo_wr        (o_fifo_wr),
        .ov_alloc_cnt     (ov_alloc_cnt),
        .ov_release_cnt   (ov_release_cnt),
        .ov_alloc_state   (ov_alloc_state)
    );

    // Scoreboard monitor: every ack must match the oldest expected grant.
    always @(negedge clk_sys) begin
        if (ov_bufid_ack != '0) begin
            exp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_grant: ack=%b bufid=%h, none expected", ov_bufid_ack, ov_bufid);
            end else begin
                e = exp_q.pop_front();
                if (ov_bufid_ack !== e.ack || ov_bufid !== e.bufid || o_fifo_rd !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL grant: ack=%b bufid=%h rd=%b, required ack=%b bufid=%h rd=1",
                             ov_bufid_ack, ov_bufid, o_fifo_rd, e.ack, e.bufid);
                end
            end
        end
    end

    task automatic cyc();
        @(negedge clk_sys);
        #1;
    endtask

    task automatic drop_acked();
        iv_bufid_req = iv_bufid_req & ~ov_bufid_ack;
    endtask

    task automatic push_grant(input int port, input logic [BUFID_W-1:0] id);
        exp_t e;
        e.ack       = '0;
        e.ack[port] = 1'b1;
        e.bufid     = id;
        exp_q.push_back(e);
    endtask

    task automatic apply_reset();
        reset            = 1'b1;
        iv_bufid_req     = '0;
        iv_fifo_rdata    = '0;
        i_fifo_empty     = 1'b0;
        iv_release_bufid = '0;
        i_release_wr     = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({ov_bufid_ack, ov_bufid, o_fifo_rd, o_fifo_wr, ov_fifo_wdata} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: ack=%b bufid=%h rd=%b wr=%b wdata=%h, required all 0",
                     ov_bufid_ack, ov_bufid, o_fifo_rd, o_fifo_wr, ov_fifo_wdata);
        end
        checks++;
        if ({ov_alloc_cnt, ov_release_cnt, ov_alloc_state} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_counters: alloc=%0d release=%0d state=%0d, required 0 0 0",
                     ov_alloc_cnt, ov_release_cnt, ov_alloc_state);
        end
    endtask

    task automatic test_single_grant();
        iv_bufid_req  = 8'b0000_0100;
        iv_fifo_rdata = 9'h005;
        push_grant(2, 9'h005);
        cyc();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL single_latency: pending=%0d, required 0", exp_q.size());
        end
        checks++;
        if (ov_alloc_state !== WAIT_S) begin
            errors++;
            $display("[TB] FAIL single_state: state=%0d, required %0d", ov_alloc_state, WAIT_S);
        end
        drop_acked();
        cyc();
        checks++;
        if (ov_bufid_ack !== '0 || o_fifo_rd !== 1'b0 || ov_bufid !== '0 || ov_alloc_state !== IDLE_S) begin
            errors++;
            $display("[TB] FAIL single_pulse: ack=%b rd=%b bufid=%h state=%0d, required 0 0 0 0",
                     ov_bufid_ack, o_fifo_rd, ov_bufid, ov_alloc_state);
        end
        checks++;
        if (ov_alloc_cnt !== 16'd1) begin
            errors++;
            $display("[TB] FAIL single_cnt: alloc=%0d, required 1", ov_alloc_cnt);
        end
    endtask

    task automatic test_all_ports();
        apply_reset();
        iv_bufid_req = '1;
        for (int g = 0; g < PORT_NUM; g++) begin
            iv_fifo_rdata = BUFID_W'(9'h100 + g);
            push_grant(g, BUFID_W'(9'h100 + g));
            cyc();
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("[TB] FAIL rr_grant%0d: pending=%0d, required 0", g, exp_q.size());
            end
            drop_acked();
            cyc();
            checks++;
            if (ov_bufid_ack !== '0) begin
                errors++;
                $display("[TB] FAIL rr_gap%0d: ack=%b, required 0", g, ov_bufid_ack);
            end
        end
        checks++;
        if (ov_alloc_cnt !== 16'd8) begin
            errors++;
            $display("[TB] FAIL rr_cnt: alloc=%0d, required 8", ov_alloc_cnt);
        end
    endtask

    task automatic test_empty_fifo();
        i_fifo_empty  = 1'b1;
        iv_fifo_rdata = 9'h0AB;
        iv_bufid_req  = 8'b0010_0000;
        for (int c = 0; c < 10; c++) begin
            cyc();
            checks++;
            if (ov_bufid_ack !== '0 || o_fifo_rd !== 1'b0) begin
                errors++;
                $display("[TB] FAIL empty_hold%0d: ack=%b rd=%b, required 0 0", c, ov_bufid_ack, o_fifo_rd);
            end
        end
        i_fifo_empty = 1'b0;
        push_grant(5, 9'h0AB);
        cyc();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL empty_release: pending=%0d, required 0", exp_q.size());
        end
        drop_acked();
        cyc();
    endtask

    task automatic test_release_during_pop();
        logic [CNT_W-1:0] a0;
        logic [CNT_W-1:0] r0;
        a0 = ov_alloc_cnt;
        r0 = ov_release_cnt;
        iv_bufid_req     = 8'b0000_0010;
        iv_fifo_rdata    = 9'h033;
        i_release_wr     = 1'b1;
        iv_release_bufid = 9'h01A;
        push_grant(1, 9'h033);
        cyc();
        checks++;
        if (o_fifo_wr !== 1'b1 || ov_fifo_wdata !== 9'h01A || o_fifo_rd !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rel_pop: wr=%b wdata=%h rd=%b, required 1 01a 1", o_fifo_wr, ov_fifo_wdata, o_fifo_rd);
        end
        drop_acked();
        i_release_wr = 1'b0;
        cyc();
        checks++;
        if (o_fifo_wr !== 1'b0 || ov_alloc_cnt !== a0 + 16'd1 || ov_release_cnt !== r0 + 16'd1) begin
            errors++;
            $display("[TB] FAIL rel_cnt: wr=%b alloc=%0d release=%0d, required 0 %0d %0d",
                     o_fifo_wr, ov_alloc_cnt, ov_release_cnt, a0 + 16'd1, r0 + 16'd1);
        end
    endtask

    task automatic test_reset_in_wait();
        iv_bufid_req  = 8'b0000_1000;
        iv_fifo_rdata = 9'h044;
        push_grant(3, 9'h044);
        cyc();
        drop_acked();
        reset = 1'b1;
        cyc();
        checks++;
        if ({ov_bufid_ack, ov_bufid, o_fifo_rd, o_fifo_wr, ov_alloc_cnt, ov_release_cnt, ov_alloc_state} !== '0) begin
            errors++;
            $display("[TB] FAIL wait_reset: ack=%b rd=%b alloc=%0d release=%0d state=%0d, required all 0",
                     ov_bufid_ack, o_fifo_rd, ov_alloc_cnt, ov_release_cnt, ov_alloc_state);
        end
        reset         = 1'b0;
        iv_bufid_req  = 8'b1000_0001;
        iv_fifo_rdata = 9'h077;
        push_grant(0, 9'h077);
        cyc();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL wait_reset_ptr: pending=%0d, required 0", exp_q.size());
        end
        drop_acked();
        cyc();
        iv_bufid_req = '0;
        cyc();
    endtask

    task automatic test_counter_wrap();
        apply_reset();
        i_release_wr = 1'b1;
        for (int c = 0; c < 65535; c++) begin
            iv_release_bufid = BUFID_W'(c);
            cyc();
        end
        i_release_wr = 1'b0;
        cyc();
        cyc();
        checks++;
        if (ov_release_cnt !== 16'hFFFF || ov_fifo_wdata !== BUFID_W'(65534)) begin
            errors++;
            $display("[TB] FAIL wrap_full: release=%h wdata=%h, required ffff %h",
                     ov_release_cnt, ov_fifo_wdata, BUFID_W'(65534));
        end
        i_release_wr = 1'b1;
        cyc();
        i_release_wr = 1'b0;
        cyc();
        checks++;
        if (ov_release_cnt !== 16'h0000 || ov_alloc_cnt !== 16'h0000 || ov_bufid_ack !== '0) begin
            errors++;
            $display("[TB] FAIL wrap_zero: release=%h alloc=%h ack=%b, required 0000 0000 0",
                     ov_release_cnt, ov_alloc_cnt, ov_bufid_ack);
        end
    endtask

    initial begin
        $display("[TB] start");
        test_reset();
        test_single_grant();
        test_all_ports();
        test_empty_fifo();
        test_release_during_pop();
        test_reset_in_wait();
        test_counter_wrap();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL leftover_grants: pending=%0d, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
